riscv_multi_ctrl_hs: RTL
========================

Name: riscv_multi_ctrl_hs

Overview:
- Next-generation multicycle RISC-V controller FSM; drives the existing multicycle datapath.
- Adds a memory req/ready handshake, so memory may take a variable number of cycles.
- Adds the full branch set (beq/bne/blt/bge/bltu/bgeu), lui, a wider ALU opcode set, a wait timeout, and a sticky trap state for illegal opcodes and timeouts.

Parameters:
- TIMEOUT, 16, maximum cycles MemReq may stay high without MemReady before a trap; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; TIMEOUT must be below 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU result == 0.
- LT  in  1  signed rs1 < rs2 (ALU flag).
- LTU  in  1  unsigned rs1 < rs2 (ALU flag).
- MemReady  in  1  memory completes the current request this cycle.
- MemReq  out  1  memory request valid.
- MemWrite  out  1  the request is a write (only with MemReq).
- AdrSrc  out  1  0=PC, 1=ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  write rd from Result.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB  out  2  00=rs2, 01=imm, 10=const 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- Trap  out  1  sticky trap flag.
- TrapCause  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Behaviour:
- State register:
  - Reset, sampled on clk: state=FETCH, wait counter=0, Trap=0, TrapCause=00.
  - While reset is high, all write/strobe outputs (MemReq, MemWrite, IRWrite, PCWrite, RegWrite) are forced to 0.
- Output timing:
  - Outputs are decoded from state. MemReady, the flags and funct3 qualify strobes combinationally.
  - Defaults: all strobes 0, mux selects 00, ALUControl add.
  - ImmSrc is decoded from op in every state.
- FETCH:
  - MemReq=1, AdrSrc=0.
  - Stay in FETCH until MemReady.
  - In the MemReady cycle: IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other op -> TRAP with cause 01
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: MemReq=1, AdrSrc=1; wait for MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1; wait for MemReady, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl per the ALU decode below; then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl per the ALU decode below; then ALUWB.
- ALU decode (funct3):
  - 000 add, except sub when R-type and funct7b5=1
  - 001 sll
  - 010 slt
  - 011 sltu
  - 100 xor
  - 101 srl, or sra when funct7b5=1
  - 110 or
  - 111 and
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=taken, where taken is:
    - 000 Zero
    - 001 !Zero
    - 100 LT
    - 101 !LT
    - 110 LTU
    - 111 !LTU
    - 010/011: not taken, go to TRAP with cause 01
  - Otherwise next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC=target), then ALUWB (rd=OldPC+4).
- LUI: ALUSrcA=11, ALUSrcB=01, add, then ALUWB.
- Wait counter:
  - Clears whenever MemReq=0 or MemReady=1.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 while MemReq=1 and MemReady=0, the next state is TRAP with cause 10.
  - A MemReady arriving in that same cycle wins; no trap.
- TRAP:
  - Trap=1, TrapCause held, all strobes 0, MemReq=0.
  - Only reset exits TRAP.
- Reset during a wait: the request is abandoned; MemReq drops in the reset cycle; FETCH restarts after reset.
- MemReady while MemReq=0 is ignored.

Test Plan:
- Fetch with MemReady delayed 3 cycles:
  - MemReq=1 for 4 cycles.
  - IRWrite and PCWrite pulse exactly once, in cycle 4.
  - Then DECODE.
- lw with 0-wait fetch and 2-wait read:
  - State sequence FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB.
  - RegWrite=1 with ResultSrc=01 for one cycle.
- sw: MEMWRITE holds MemWrite=1 and AdrSrc=1 until MemReady; RegWrite never asserts.
- Branches:
  - bne with Zero=1: PCWrite=0.
  - bltu with LTU=1: PCWrite=1.
  - bge with LT=1: PCWrite=0.
- TIMEOUT=4, MemReady held low in FETCH:
  - Trap=1, TrapCause=10 after 4 MemReq cycles.
  - Stays in TRAP; a reset pulse returns to FETCH with Trap=0.
- op=1111111 in DECODE: TRAP, TrapCause=01, no further MemReq.
- sub/sra decode:
  - R-type funct3=000 with funct7b5=1: ALUControl=0001.
  - I-type funct3=000 with funct7b5=1: 0000.
  - funct3=101 with funct7b5=1: 1001.

Source files
------------

// File: rtl/riscv_multi_ctrl_hs.sv
// Multicycle RISC-V controller FSM with a memory req/ready handshake,
// a full branch set, a wait-timeout watchdog and a sticky trap state.
module riscv_multi_ctrl_hs #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LT,
  input  logic       LTU,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Trap,
  output logic [1:0] TrapCause
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [1:0]       cause, cause_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             taken;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_r);
    unique case (f3)
      3'b000:  alu_dec = (is_r && f7) ? 4'b0001 : 4'b0000;
      3'b001:  alu_dec = 4'b0111;
      3'b010:  alu_dec = 4'b0101;
      3'b011:  alu_dec = 4'b0110;
      3'b100:  alu_dec = 4'b0100;
      3'b101:  alu_dec = f7 ? 4'b1001 : 4'b1000;
      3'b110:  alu_dec = 4'b0011;
      default: alu_dec = 4'b0010;
    endcase
  endfunction

  always_comb begin
    unique case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = LT;
      3'b101:  taken = !LT;
      3'b110:  taken = LTU;
      3'b111:  taken = !LTU;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    cause_n    = cause;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 4'b0000;
    Trap       = (state == S_TRAP);
    TrapCause  = cause;

    unique case (op)
      OP_STORE: ImmSrc = 3'b001;
      OP_BR:    ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      OP_LUI:   ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase

    unique case (state)
      S_FETCH: begin
        MemReq = 1'b1;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          state_n   = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_R:              state_n = S_EXECR;
          OP_I:              state_n = S_EXECI;
          OP_BR:             state_n = S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          OP_LUI:            state_n = S_LUI;
          default: begin
            state_n = S_TRAP;
            cause_n = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) state_n = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7b5, 1'b1);
        state_n    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, funct7b5, 1'b0);
        state_n    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 4'b0001;
        PCWrite    = taken;
        if (funct3[2:1] == 2'b01) begin
          state_n = S_TRAP;
          cause_n = 2'b01;
        end else begin
          state_n = S_FETCH;
        end
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_n = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_n = S_ALUWB;
      end
      default: ;
    endcase

    // Watchdog overrides the handshake wait; a same-cycle MemReady still wins.
    if ((TIMEOUT != 0) && MemReq && !MemReady && (wait_cnt == WAIT_LAST)) begin
      state_n = S_TRAP;
      cause_n = 2'b10;
    end

    if (reset) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      cause    <= 2'b00;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      if (!MemReq || MemReady)
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
